// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter: FSM encoding,
// default character width, index-width and one-hot helpers.
package uart_pkg;

  localparam int W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_ACK   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or above i_ptr,
// wrapping at N_REQ, returned as one-hot, index and an any-hit flag.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  logic [IW-1:0] w_cand [N_REQ];

  // Candidate gi is the requester gi positions after the pointer, modulo N_REQ.
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [IW:0] w_sum;
    assign w_sum = {1'b0, i_ptr} + (IW+1)'(gi);
    assign w_cand[gi] = (w_sum >= (IW+1)'(N_REQ)) ? IW'(w_sum - (IW+1)'(N_REQ))
                                                  : IW'(w_sum);
  end

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[w_cand[i]]) begin
        o_idx = w_cand[i];
        o_any = 1'b1;
      end
    end
    o_onehot = o_any ? N_REQ'(onehot8(3'(o_idx))) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters: round-robin
// grant held for a whole packet, per-byte write/busy handshake, gap watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int W           = W_DEFAULT,
  parameter int GAP_TIMEOUT = 1024,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       tx_data,
  output logic               tx_wr,
  input  logic               tx_busy,
  output logic [N_REQ-1:0]   grant,
  output logic               drop
);

  localparam int IW = clog2_min1(N_REQ);
  localparam int GW = clog2_min1(GAP_TIMEOUT);
  localparam int AW = clog2_min1(ACK_TIMEOUT + 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [N_REQ-1:0]   r_grant;
  logic [IW-1:0]      r_owner;
  logic [IW-1:0]      r_rr_ptr;
  logic [W-1:0]       r_tx_data;
  logic               r_last_f;
  logic [GW-1:0]      r_gap_cnt;
  logic [AW-1:0]      r_ack_cnt;

  logic [N_REQ-1:0]   w_pick_onehot;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_any;
  logic [W-1:0]       w_owner_data;
  logic [IW-1:0]      w_owner_inc;
  logic               w_fire;
  logic               w_gap_tick;
  logic               w_gap_expire;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .i_req    (req_valid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  assign w_owner_data = req_data[int'(r_owner)*W +: W];
  assign w_owner_inc  = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    w_gap_tick   = 1'b0;
    w_gap_expire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) w_state_next = ST_SEND;
      end
      ST_SEND: begin
        // A busy transmitter pauses both sending and the gap watchdog.
        if (!tx_busy) begin
          if (req_valid[r_owner]) begin
            w_fire       = 1'b1;
            w_state_next = ST_ACK;
          end else begin
            w_gap_tick = 1'b1;
            if (r_gap_cnt == GW'(GAP_TIMEOUT - 1)) begin
              w_gap_expire = 1'b1;
              w_state_next = ST_IDLE;
            end
          end
        end
      end
      ST_ACK: begin
        if (tx_busy || r_ack_cnt == AW'(ACK_TIMEOUT - 1)) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!tx_busy) w_state_next = r_last_f ? ST_IDLE : ST_SEND;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_tx_data <= '0;
      r_last_f  <= 1'b0;
      r_gap_cnt <= '0;
      r_ack_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_grant   <= w_pick_onehot;
            r_owner   <= w_pick_idx;
            r_gap_cnt <= '0;
          end
        end
        ST_SEND: begin
          if (w_fire) begin
            r_tx_data <= w_owner_data;
            r_last_f  <= req_last[r_owner];
            r_gap_cnt <= '0;
            r_ack_cnt <= '0;
          end else if (w_gap_expire) begin
            r_grant   <= '0;
            r_rr_ptr  <= w_owner_inc;
            r_gap_cnt <= '0;
          end else if (w_gap_tick) begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        ST_ACK: begin
          r_ack_cnt <= r_ack_cnt + 1'b1;
        end
        ST_DRAIN: begin
          if (!tx_busy && r_last_f) begin
            r_grant  <= '0;
            r_rr_ptr <= w_owner_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Data is forwarded during the strobe cycle so it is valid from tx_wr onward.
  assign tx_wr     = w_fire;
  assign req_ready = w_fire ? r_grant : '0;
  assign tx_data   = w_fire ? w_owner_data : r_tx_data;
  assign grant     = r_grant;
  assign drop      = w_gap_expire;

endmodule
